// File: rtl/mem_lsu_pkg.sv
// Shared constants for the MEM-stage load/store unit: widths, funct3 codes,
// FSM encodings and the access legality rule.
package mem_lsu_pkg;

  localparam int          XLEN           = 32;
  localparam int          XREG_ADDRWIDTH = 5;
  localparam logic        RST_ENABLE     = 1'b1;
  localparam logic [31:0] ZERO_32BIT     = 32'h0000_0000;
  localparam logic        FALSE          = 1'b0;
  localparam logic        TRUE           = 1'b1;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_WAIT = 2'b01,
    LSU_DONE = 2'b10
  } lsu_state_e;

  // Unsigned widths exist only for loads; H needs an even address, W a word-aligned one.
  function automatic logic lsu_access_ok(input logic [2:0] f3, input logic [1:0] a,
                                         input logic is_store);
    logic ok;
    ok = FALSE;
    case (f3)
      LSU_B:  ok = TRUE;
      LSU_H:  ok = !a[0];
      LSU_W:  ok = (a == 2'b00);
      LSU_BU: ok = !is_store;
      LSU_HU: ok = !is_store && !a[0];
      default: ok = FALSE;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lsu_load_ext.sv
// Selects the addressed byte/halfword of a loaded word and sign- or
// zero-extends it according to funct3.
module mem_load_ext
  import mem_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      addr_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_i)
      2'b00:   byte_v = word_i[7:0];
      2'b01:   byte_v = word_i[15:8];
      2'b10:   byte_v = word_i[23:16];
      default: byte_v = word_i[31:24];
    endcase
    half_v = addr_i[1] ? word_i[31:16] : word_i[15:0];

    case (funct3_i)
      LSU_B:   data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      LSU_H:   data_o = {{(XLEN-16){half_v[15]}}, half_v};
      LSU_BU:  data_o = {{(XLEN-8){1'b0}}, byte_v};
      LSU_HU:  data_o = {{(XLEN-16){1'b0}}, half_v};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: runs a req/ack access to data memory, stalls the
// pipeline while it is outstanding and hands the rd value to mem_wb.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int XREG_ADDRWIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic [XLEN-1:0]           alu_result_in,
  input  logic [XLEN-1:0]           store_data_in,
  input  logic                      mem_rd_in,
  input  logic                      mem_wr_in,
  input  logic [2:0]                funct3_in,
  input  logic                      rd_en_in,
  input  logic [XREG_ADDRWIDTH-1:0] rd_addr_in,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [XLEN-1:0]           dmem_addr,
  output logic [XLEN-1:0]           dmem_wdata,
  output logic [3:0]                dmem_be,
  input  logic                      dmem_ack,
  input  logic [XLEN-1:0]           dmem_rdata,
  output logic [XLEN-1:0]           rd_out,
  output logic                      rd_en_out,
  output logic [XREG_ADDRWIDTH-1:0] rd_addr_out,
  output logic                      stall_req_out,
  output logic                      misalign_exc_out,
  output lsu_state_e                state_dbg_o
);

  // Handshake: dmem_req rises in IDLE and stays high with stable addr/we/wdata/be
  // until the cycle in which dmem_ack pulses; ack is only looked at in WAIT.

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [XLEN-1:0] load_val;
  logic            is_mem_op;
  logic            access_ok;

  assign is_mem_op = valid_in && (mem_rd_in || mem_wr_in);
  assign access_ok = lsu_access_ok(funct3_in, alu_result_in[1:0], mem_wr_in);

  mem_load_ext #(.XLEN(XLEN)) u_load_ext (
    .word_i   (rdata_q),
    .addr_i   (alu_result_in[1:0]),
    .funct3_i (funct3_in),
    .data_o   (load_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LSU_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    rdata_d          = rdata_q;
    dmem_req         = 1'b0;
    stall_req_out    = 1'b0;
    misalign_exc_out = 1'b0;
    rd_out           = alu_result_in;
    rd_en_out        = 1'b0;
    rd_addr_out      = rd_addr_in;

    case (state_q)
      LSU_IDLE: begin
        if (valid_in && !is_mem_op) begin
          rd_en_out = rd_en_in;
        end else if (is_mem_op && !access_ok) begin
          misalign_exc_out = 1'b1;
        end else if (is_mem_op) begin
          dmem_req      = 1'b1;
          stall_req_out = 1'b1;
          state_d       = LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        dmem_req      = 1'b1;
        stall_req_out = 1'b1;
        if (dmem_ack) begin
          rdata_d = dmem_rdata;
          state_d = LSU_DONE;
        end
      end
      LSU_DONE: begin
        state_d = LSU_IDLE;
        if (mem_rd_in) begin
          rd_out    = load_val;
          rd_en_out = rd_en_in;
        end
      end
      default: state_d = LSU_IDLE;
    endcase

    // The pass-through path is combinational, so reset has to mask it too.
    if (rst) begin
      dmem_req         = 1'b0;
      stall_req_out    = 1'b0;
      misalign_exc_out = 1'b0;
      rd_out           = '0;
      rd_en_out        = 1'b0;
      rd_addr_out      = '0;
    end
  end

  assign state_dbg_o = state_q;
  assign dmem_we     = dmem_req && mem_wr_in;
  assign dmem_addr   = {alu_result_in[XLEN-1:2], 2'b00};

  always_comb begin
    dmem_wdata = store_data_in;
    dmem_be    = 4'b1111;
    if (mem_wr_in) begin
      case (funct3_in)
        LSU_B: begin
          dmem_wdata = {4{store_data_in[7:0]}};
          dmem_be    = 4'b0001 << alu_result_in[1:0];
        end
        LSU_H: begin
          dmem_wdata = {2{store_data_in[15:0]}};
          dmem_be    = alu_result_in[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          dmem_wdata = store_data_in;
          dmem_be    = 4'b1111;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed plus randomized bench for mem_lsu against an arithmetic reference
// model of load extraction, store lane encoding and access timing.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk, rst;
  logic        valid_in, mem_rd_in, mem_wr_in, rd_en_in;
  logic [31:0] alu_result_in, store_data_in, dmem_rdata;
  logic [2:0]  funct3_in;
  logic [4:0]  rd_addr_in;
  logic        dmem_ack;
  logic        dmem_req, dmem_we, rd_en_out, stall_req_out, misalign_exc_out;
  logic [31:0] dmem_addr, dmem_wdata, rd_out;
  logic [3:0]  dmem_be;
  logic [4:0]  rd_addr_out;
  lsu_state_e  state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  mem_lsu dut (
    .clk              (clk),
    .rst              (rst),
    .valid_in         (valid_in),
    .alu_result_in    (alu_result_in),
    .store_data_in    (store_data_in),
    .mem_rd_in        (mem_rd_in),
    .mem_wr_in        (mem_wr_in),
    .funct3_in        (funct3_in),
    .rd_en_in         (rd_en_in),
    .rd_addr_in       (rd_addr_in),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_be          (dmem_be),
    .dmem_ack         (dmem_ack),
    .dmem_rdata       (dmem_rdata),
    .rd_out           (rd_out),
    .rd_en_out        (rd_en_out),
    .rd_addr_out      (rd_addr_out),
    .stall_req_out    (stall_req_out),
    .misalign_exc_out (misalign_exc_out),
    .state_dbg_o      (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  function automatic bit ref_legal(input logic [2:0] f3, input logic [31:0] a, input bit is_load);
    int ai;
    ai = int'(a % 4);
    if (f3 == 3'd0) return 1;
    if (f3 == 3'd1) return (ai % 2) == 0;
    if (f3 == 3'd2) return ai == 0;
    if (f3 == 3'd4) return is_load;
    if (f3 == 3'd5) return is_load && (ai % 2) == 0;
    return 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] s;
    s = w >> (8 * (a % 4));
    case (f3)
      3'd0:    return ((s & 32'hFF) ^ 32'h80) - 32'h80;
      3'd1:    return ((s & 32'hFFFF) ^ 32'h8000) - 32'h8000;
      3'd4:    return s & 32'hFF;
      3'd5:    return s & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_be(input bit is_load, input logic [2:0] f3, input logic [31:0] a);
    if (is_load || f3 == 3'd2) return 32'd15;
    if (f3 == 3'd0) return 32'd1 << (a % 4);
    return 32'd3 << (a % 4);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // Scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Driver tasks
  task automatic idle_inputs();
    valid_in = 0; mem_rd_in = 0; mem_wr_in = 0; funct3_in = 3'd0;
    alu_result_in = 0; store_data_in = 0; rd_en_in = 0; rd_addr_in = 0;
    dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic do_mem(input bit is_load, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rword, input int dly,
                        input bit ren, input logic [4:0] raddr);
    int stalls;
    @(posedge clk); #1;
    valid_in = 1; mem_rd_in = is_load; mem_wr_in = !is_load; funct3_in = f3;
    alu_result_in = addr; store_data_in = sdata; rd_en_in = ren; rd_addr_in = raddr;
    stalls = 0;
    for (int k = 0; k <= dly; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        dmem_ack = (k == dly);
        dmem_rdata = (k == dly) ? rword : $urandom;
      end
      @(negedge clk);
      stalls += int'(stall_req_out);
      if (k == 0) begin
        chk("req_issue", {31'b0, dmem_req}, 32'd1);
        chk("we", {31'b0, dmem_we}, {31'b0, !is_load});
        chk("addr", dmem_addr, addr & 32'hFFFF_FFFC);
        chk("be", {28'b0, dmem_be}, ref_be(is_load, f3, addr));
        if (!is_load) chk("wdata", dmem_wdata, ref_wdata(f3, sdata));
        chk("no_exc", {31'b0, misalign_exc_out}, 32'd0);
        chk("rd_en_busy", {31'b0, rd_en_out}, 32'd0);
      end else if (k == dly) begin
        chk("req_held", {31'b0, dmem_req}, 32'd1);
        chk("addr_held", dmem_addr, addr & 32'hFFFF_FFFC);
      end
    end
    @(posedge clk); #1;
    dmem_ack = 1; dmem_rdata = $urandom;
    @(negedge clk);
    chk("stall_cycles", stalls, dly + 1);
    chk("done_state", {30'b0, state_dbg}, {30'b0, LSU_DONE});
    chk("done_req", {31'b0, dmem_req}, 32'd0);
    chk("done_stall", {31'b0, stall_req_out}, 32'd0);
    chk("done_rd_en", {31'b0, rd_en_out}, {31'b0, is_load && ren});
    if (is_load) begin
      chk("load_val", rd_out, ref_load(rword, addr, f3));
      chk("load_rd_addr", {27'b0, rd_addr_out}, {27'b0, raddr});
    end
    @(posedge clk); #1;
    dmem_ack = 0;
    valid_in = 0; mem_rd_in = 0; mem_wr_in = 0;
    @(negedge clk);
    chk("back_idle", {30'b0, state_dbg}, {30'b0, LSU_IDLE});
    chk("idle_req", {31'b0, dmem_req}, 32'd0);
  endtask

  task automatic do_bad(input bit is_load, input logic [2:0] f3, input logic [31:0] addr);
    @(posedge clk); #1;
    valid_in = 1; mem_rd_in = is_load; mem_wr_in = !is_load; funct3_in = f3;
    alu_result_in = addr; rd_en_in = 1; rd_addr_in = 5'd9;
    @(negedge clk);
    chk("exc", {31'b0, misalign_exc_out}, 32'd1);
    chk("exc_req", {31'b0, dmem_req}, 32'd0);
    chk("exc_stall", {31'b0, stall_req_out}, 32'd0);
    chk("exc_rd_en", {31'b0, rd_en_out}, 32'd0);
    @(negedge clk);
    chk("exc_state", {30'b0, state_dbg}, {30'b0, LSU_IDLE});
    chk("exc_req2", {31'b0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    valid_in = 0; mem_rd_in = 0; mem_wr_in = 0;
  endtask

  task automatic do_alu(input logic [31:0] res, input bit ren, input logic [4:0] raddr);
    @(posedge clk); #1;
    valid_in = 1; mem_rd_in = 0; mem_wr_in = 0; alu_result_in = res;
    rd_en_in = ren; rd_addr_in = raddr; funct3_in = 3'($urandom_range(0, 7));
    #1;
    chk("alu_rd", rd_out, res);
    chk("alu_rd_en", {31'b0, rd_en_out}, {31'b0, ren});
    chk("alu_rd_addr", {27'b0, rd_addr_out}, {27'b0, raddr});
    chk("alu_stall", {31'b0, stall_req_out}, 32'd0);
    chk("alu_req", {31'b0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    valid_in = 0;
  endtask

  task automatic do_invalid();
    @(posedge clk); #1;
    valid_in = 0; mem_rd_in = 1; mem_wr_in = 0; funct3_in = 3'd2;
    alu_result_in = $urandom; rd_en_in = 1;
    @(negedge clk);
    chk("inv_rd_en", {31'b0, rd_en_out}, 32'd0);
    chk("inv_req", {31'b0, dmem_req}, 32'd0);
    chk("inv_stall", {31'b0, stall_req_out}, 32'd0);
    @(posedge clk); #1;
    mem_rd_in = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    // Drive a pass-through instruction during reset: outputs must still read zero.
    valid_in = 1; alu_result_in = 32'h55; rd_en_in = 1; rd_addr_in = 5'd4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {30'b0, state_dbg}, {30'b0, LSU_IDLE});
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_stall", {31'b0, stall_req_out}, 32'd0);
    chk("rst_exc", {31'b0, misalign_exc_out}, 32'd0);
    chk("rst_rd", rd_out, 32'd0);
    chk("rst_rd_en", {31'b0, rd_en_out}, 32'd0);
    chk("rst_rd_addr", {27'b0, rd_addr_out}, 32'd0);
    idle_inputs();
    @(posedge clk); #1;
    rst = 0;

    do_mem(1, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 2, 1, 5'd3);
    do_mem(1, 3'd0, 32'h103, 32'h0, 32'h80FF_0000, 1, 1, 5'd5);
    do_mem(1, 3'd4, 32'h103, 32'h0, 32'h80FF_0000, 1, 1, 5'd5);
    do_mem(0, 3'd1, 32'h102, 32'h1234ABCD, 32'h0, 1, 1, 5'd6);
    do_bad(1, 3'd2, 32'h101);
    do_bad(1, 3'd3, 32'h100);
    do_alu(32'h5, 1, 5'd7);
    do_invalid();

    for (int i = 0; i < 60; i++) begin
      int kind;
      logic [31:0] a;
      logic [2:0] f3;
      bit ld;
      kind = $urandom_range(0, 5);
      a = $urandom;
      f3 = 3'($urandom_range(0, 7));
      ld = (kind != 1);
      if (kind <= 2) begin
        if (ref_legal(f3, a, ld))
          do_mem(ld, f3, a, $urandom, $urandom, $urandom_range(1, 3), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)));
        else
          do_bad(ld, f3, a);
      end else if (kind <= 4) begin
        do_alu($urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      end else begin
        do_invalid();
      end
    end

    // Reset while waiting for ack, then a late ack after release.
    @(posedge clk); #1;
    valid_in = 1; mem_rd_in = 1; funct3_in = 3'd2; alu_result_in = 32'h200; rd_en_in = 1; rd_addr_in = 5'd8;
    @(posedge clk); #1;
    @(negedge clk);
    chk("wait_state", {30'b0, state_dbg}, {30'b0, LSU_WAIT});
    #2;
    rst = 1;
    idle_inputs();
    #1;
    chk("mid_rst_req", {31'b0, dmem_req}, 32'd0);
    chk("mid_rst_state", {30'b0, state_dbg}, {30'b0, LSU_IDLE});
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    dmem_ack = 1; dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("late_ack_req", {31'b0, dmem_req}, 32'd0);
    chk("late_ack_stall", {31'b0, stall_req_out}, 32'd0);
    @(posedge clk); #1;
    dmem_ack = 0;
    @(negedge clk);
    chk("late_ack_state", {30'b0, state_dbg}, {30'b0, LSU_IDLE});
    chk("late_ack_rd_en", {31'b0, rd_en_out}, 32'd0);
    chk("late_ack_rd", rd_out, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
